traffic_phase_sched: RTL and testbench

Phase scheduler for the four-approach intersection. It turns the eight road sensors into a round-robin green sequence with variable green length. Every phase change passes through yellow and all-red clearance intervals. An optional emergency-vehicle preemption path can cut a green short. It drives the lamp outputs and sits directly between the sensor front end and the lamp drivers.

---
 rtl/traffic_phase_sched.sv | 164 ++++++++++++++++
 tb/tb_traffic_phase_sched.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sched.sv
// Round-robin four-approach signal phase scheduler with yellow and all-red clearance.
// Define TRAFFIC_PREEMPT_EN to enable emergency-vehicle preemption on emg.
module traffic_phase_sched #(
    parameter int SLOT   = 5,
    parameter int YEL    = 2,
    parameter int ALLRED = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:1] sensors,
    input  logic [4:1] emg,
    output logic [4:1] traffic,
    output logic [4:1] yellow,
    output logic       preempt
);
    localparam int CW = $clog2(2 * SLOT + 1);
    localparam logic [CW-1:0] SLOT_M1   = CW'(SLOT - 1);
    localparam logic [CW-1:0] SLOT2_M1  = CW'(2 * SLOT - 1);
    localparam logic [CW-1:0] YEL_M1    = CW'(YEL - 1);
    localparam logic [CW-1:0] ALLRED_M1 = CW'(ALLRED - 1);

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            preempt_q, preempt_d;
    logic [4:1]      traffic_q, traffic_d;
    logic [4:1]      yellow_q, yellow_d;

    logic [3:0][1:0] demand;
    logic            rr_valid;
    logic [1:0]      rr_road;
    logic [CW-1:0]   rr_dur;
    logic            emg_any;
    logic [1:0]      emg_road;
    logic            emg_hold;

    assign demand = sensors;

`ifdef TRAFFIC_PREEMPT_EN
    always_comb begin
        emg_any  = |emg;
        emg_road = emg[1] ? 2'd0 : emg[2] ? 2'd1 : emg[3] ? 2'd2 : 2'd3;
        emg_hold = |(emg & (4'b0001 << ptr_q));
    end
    assign preempt = preempt_q;
`else
    logic unused_emg;
    assign unused_emg = ^emg;
    assign emg_any    = 1'b0;
    assign emg_road   = 2'd0;
    assign emg_hold   = 1'b0;
    assign preempt    = 1'b0;
`endif

    // Scan ptr+4 down to ptr+1 so the nearest road after ptr is the last, winning, assignment.
    always_comb begin
        logic [1:0] r;
        r        = ptr_q;
        rr_valid = 1'b0;
        rr_road  = ptr_q;
        for (int i = 4; i >= 1; i--) begin
            r = ptr_q + 2'(i);
            if (demand[r] != 2'b00) begin
                rr_valid = 1'b1;
                rr_road  = r;
            end
        end
        rr_dur = (&demand[rr_road]) ? SLOT2_M1 : SLOT_M1;
    end

    always_comb begin
        logic do_select;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        preempt_d = preempt_q;
        do_select = 1'b0;

        case (state_q)
            IDLE:  do_select = 1'b1;
            GREEN: begin
                if (preempt_q) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!emg_hold) begin
                        state_d   = YELLOW;
                        cnt_d     = YEL_M1;
                        preempt_d = 1'b0;
                    end
                end else if (emg_any && emg_road != ptr_q) begin
                    state_d = YELLOW;
                    cnt_d   = YEL_M1;
                end else if (emg_any) begin
                    preempt_d = 1'b1;
                    cnt_d     = SLOT_M1;
                end else if (cnt_q == '0) begin
                    state_d = YELLOW;
                    cnt_d   = YEL_M1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            YELLOW: begin
                if (cnt_q == '0) begin
                    state_d = CLEAR;
                    cnt_d   = ALLRED_M1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == '0) do_select = 1'b1;
                else             cnt_d     = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (do_select) begin
            if (emg_any) begin
                state_d   = GREEN;
                ptr_d     = emg_road;
                cnt_d     = SLOT_M1;
                preempt_d = 1'b1;
            end else if (rr_valid) begin
                state_d   = GREEN;
                ptr_d     = rr_road;
                cnt_d     = rr_dur;
                preempt_d = 1'b0;
            end else begin
                state_d   = IDLE;
                cnt_d     = '0;
                preempt_d = 1'b0;
            end
        end

        traffic_d = (state_d == GREEN)  ? (4'b0001 << ptr_d) : 4'b0000;
        yellow_d  = (state_d == YELLOW) ? (4'b0001 << ptr_d) : 4'b0000;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= 2'd3;
            preempt_q <= 1'b0;
            traffic_q <= 4'b0000;
            yellow_q  <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            preempt_q <= preempt_d;
            traffic_q <= traffic_d;
            yellow_q  <= yellow_d;
        end
    end

    assign traffic = traffic_q;
    assign yellow  = yellow_q;
endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched at default timing (SLOT=5, YEL=2, ALLRED=1).
module tb_traffic_phase_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic [8:1] sensors;
    logic [4:1] emg;
    logic [4:1] traffic;
    logic [4:1] yellow;
    logic       preempt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    traffic_phase_sched dut (
        .clk     (clk),
        .rst     (rst),
        .sensors (sensors),
        .emg     (emg),
        .traffic (traffic),
        .yellow  (yellow),
        .preempt (preempt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks the lamps of the current segment, then measures how many cycles they hold.
    task automatic seg(input string tag, input logic [4:1] exp_t, input logic [4:1] exp_y,
                       input int exp_len);
        logic [7:0] lamps;
        int         n;
        check({tag, "_traffic"}, 32'(traffic), 32'(exp_t));
        check({tag, "_yellow"}, 32'(yellow), 32'(exp_y));
        lamps = {traffic, yellow};
        n = 1;
        tick();
        while ({traffic, yellow} == lamps && n < 64) begin
            n++;
            tick();
        end
        check({tag, "_len"}, 32'(n), 32'(exp_len));
    endtask

    task automatic do_reset(input logic [8:1] s);
        rst     = 1'b0;
        sensors = s;
        emg     = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        logic [4:1] road_lamp [4];
        int         len_mix   [4];
        logic [8:0] exp_tab   [12];
        int         lit;

        road_lamp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        len_mix   = '{10, 5, 10, 5};

        // Reset with full demand, then round robin over congested roads.
        rst     = 1'b0;
        sensors = 8'hFF;
        emg     = 4'b0000;
        tick();
        tick();
        check("rst_traffic", 32'(traffic), 32'h0);
        check("rst_yellow", 32'(yellow), 32'h0);
        check("rst_preempt", 32'(preempt), 32'h0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            seg($sformatf("ff_g%0d", i), road_lamp[i % 4], 4'b0000, 10);
            seg($sformatf("ff_y%0d", i), 4'b0000, road_lamp[i % 4], 2);
            seg($sformatf("ff_r%0d", i), 4'b0000, 4'b0000, 1);
        end

        rst = 1'b0;
        tick();
        check("midrst_traffic", 32'(traffic), 32'h0);
        check("midrst_yellow", 32'(yellow), 32'h0);

        // Mixed light and congested demand.
        do_reset(8'b0111_0111);
        for (int i = 0; i < 4; i++) begin
            seg($sformatf("mix_g%0d", i), road_lamp[i], 4'b0000, len_mix[i]);
            seg($sformatf("mix_y%0d", i), 4'b0000, road_lamp[i], 2);
            seg($sformatf("mix_r%0d", i), 4'b0000, 4'b0000, 1);
        end

        // Only roads 1 and 4 request.
        do_reset(8'b0100_0001);
        seg("alt_g1", 4'b0001, 4'b0000, 5);
        seg("alt_y1", 4'b0000, 4'b0001, 2);
        seg("alt_r1", 4'b0000, 4'b0000, 1);
        seg("alt_g4", 4'b1000, 4'b0000, 5);
        seg("alt_y4", 4'b0000, 4'b1000, 2);
        seg("alt_r4", 4'b0000, 4'b0000, 1);
        seg("alt_g1b", 4'b0001, 4'b0000, 5);

        // No demand keeps lamps dark; a single request wakes the scheduler next edge.
        do_reset(8'h00);
        lit = 0;
        for (int i = 0; i < 20; i++) begin
            if ((traffic | yellow) != 4'b0000) lit++;
            tick();
        end
        check("idle_dark", 32'(lit), 32'h0);
        sensors = 8'b0100_0000;
        tick();
        seg("idle_g4", 4'b1000, 4'b0000, 5);

        // Emergency request for road 3 arriving in the fourth cycle of a road-1 green.
`ifdef TRAFFIC_PREEMPT_EN
        exp_tab = '{9'b0000_0001_0, 9'b0000_0001_0, 9'b0000_0000_0,
                    9'b0100_0000_1, 9'b0100_0000_1, 9'b0100_0000_1,
                    9'b0100_0000_1, 9'b0100_0000_1, 9'b0000_0100_0,
                    9'b0000_0100_0, 9'b0000_0000_0, 9'b1000_0000_0};
`else
        exp_tab = '{9'b0001_0000_0, 9'b0001_0000_0, 9'b0001_0000_0,
                    9'b0001_0000_0, 9'b0001_0000_0, 9'b0001_0000_0,
                    9'b0001_0000_0, 9'b0000_0001_0, 9'b0000_0001_0,
                    9'b0000_0000_0, 9'b0010_0000_0, 9'b0010_0000_0};
`endif
        do_reset(8'hFF);
        tick();
        tick();
        emg = 4'b0100;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("emg_k%0d", k), 32'({traffic, yellow, preempt}), 32'(exp_tab[k]));
            if (k == 7) emg = 4'b0000;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
